usb_blk_ep_sched: RTL and testbench

// - Routes the single bulk channel of the USB transfer FSM to NUM_EP per-endpoint streams (EP1..EP<NUM_EP>).
// - Answers has-data/ready for the addressed endpoint in the token cycle, latches the endpoint for the transaction and steers IN/OUT bytes.
// - Generates OUT tlast via a one-byte hold stage and drops NAKed or oversize OUT payload.

---
 rtl/usb_blk_ep_sched_pkg.sv | 21 ++
 rtl/usb_blk_ep_sched_if.sv | 39 +++
 rtl/usb_blk_ep_sched_out_hold.sv | 46 ++++
 rtl/usb_blk_ep_sched.sv | 153 +++++++++++++++
 tb/tb_usb_blk_ep_sched.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/usb_blk_ep_sched_pkg.sv
// Shared types and constants for the bulk endpoint scheduler.
// Token and handshake codes as seen by the transfer FSM.
package usb_blk_ep_sched_pkg;

  localparam logic [1:0] TOK_OUT   = 2'b00;
  localparam logic [1:0] TOK_IN    = 2'b10;
  localparam logic [1:0] TOK_SETUP = 2'b11;

  localparam logic [3:0] HSK_ACK   = 4'b0010;
  localparam logic [3:0] HSK_NAK   = 4'b1010;
  localparam logic [3:0] HSK_STALL = 4'b1110;
  localparam logic [3:0] HSK_NYET  = 4'b0110;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_IN,
    ST_OUT,
    ST_FLUSH
  } sched_state_t;

endpackage

// File: rtl/usb_blk_ep_sched_if.sv
// Bulk channel between the USB transfer FSM and the scheduler.
// master = transfer FSM, slave = endpoint scheduler.
interface usb_blk_ep_sched_if;

  logic       trn_start;
  logic [1:0] trn_type;
  logic [3:0] trn_endpoint;
  logic       blk_in_xfer;
  logic       blk_out_xfer;
  logic       blk_xfer_in_has_data;
  logic [7:0] blk_xfer_in_data;
  logic       blk_xfer_in_data_valid;
  logic       blk_xfer_in_data_ready;
  logic       blk_xfer_in_data_last;
  logic       blk_xfer_out_ready_read;
  logic [7:0] blk_xfer_out_data;
  logic       blk_xfer_out_data_valid;

  modport master (
    output trn_start, trn_type, trn_endpoint,
    output blk_in_xfer, blk_out_xfer,
    output blk_xfer_in_data_ready,
    output blk_xfer_out_data, blk_xfer_out_data_valid,
    input  blk_xfer_in_has_data, blk_xfer_in_data,
    input  blk_xfer_in_data_valid, blk_xfer_in_data_last,
    input  blk_xfer_out_ready_read
  );

  modport slave (
    input  trn_start, trn_type, trn_endpoint,
    input  blk_in_xfer, blk_out_xfer,
    input  blk_xfer_in_data_ready,
    input  blk_xfer_out_data, blk_xfer_out_data_valid,
    output blk_xfer_in_has_data, blk_xfer_in_data,
    output blk_xfer_in_data_valid, blk_xfer_in_data_last,
    output blk_xfer_out_ready_read
  );

endinterface

// File: rtl/usb_blk_ep_sched_out_hold.sv
// One-byte OUT hold stage: delays the stream by one byte so the
// final byte can be tagged with tlast when the transaction ends.
module usb_blk_ep_sched_out_hold (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] din,
  input  logic       flush,
  output logic       emit_valid,
  output logic [7:0] emit_data,
  output logic       emit_last
);

  logic       full;
  logic [7:0] data;

  always_ff @(posedge clk) begin
    if (rst) begin
      full       <= 1'b0;
      data       <= '0;
      emit_valid <= 1'b0;
      emit_data  <= '0;
      emit_last  <= 1'b0;
    end else begin
      emit_valid <= 1'b0;
      emit_data  <= '0;
      emit_last  <= 1'b0;
      if (load) begin
        if (full) begin
          emit_valid <= 1'b1;
          emit_data  <= data;
        end
        data <= din;
        full <= 1'b1;
      end else if (flush) begin
        if (full) begin
          emit_valid <= 1'b1;
          emit_data  <= data;
          emit_last  <= 1'b1;
        end
        full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/usb_blk_ep_sched.sv
// Bulk endpoint scheduler: fans the single bulk channel of the
// transfer FSM out to NUM_EP per-endpoint IN/OUT streams.
module usb_blk_ep_sched
  import usb_blk_ep_sched_pkg::*;
#(
  parameter int NUM_EP  = 4,
  parameter int MAX_PKT = 512
) (
  input  logic                clk,
  input  logic                rst,
  usb_blk_ep_sched_if.slave   bus,
  input  logic [NUM_EP-1:0]   ep_in_has_data,
  input  logic [8*NUM_EP-1:0] ep_in_tdata,
  input  logic [NUM_EP-1:0]   ep_in_tvalid,
  input  logic [NUM_EP-1:0]   ep_in_tlast,
  output logic [NUM_EP-1:0]   ep_in_tready,
  input  logic [NUM_EP-1:0]   ep_out_ready,
  output logic [7:0]          ep_out_tdata,
  output logic [NUM_EP-1:0]   ep_out_tvalid,
  output logic                ep_out_tlast,
  output logic                ep_out_err
);

  localparam int CW = $clog2(MAX_PKT + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_PKT);

  sched_state_t state;
  logic [3:0]   sel_ep;
  logic         acc;
  logic [CW-1:0] count;
  logic         in_seen;
  logic         nak_wait;
  logic         out_xfer_q;
  logic         err_done;

  logic [3:0]   ep;
  logic         has_data;
  logic         ready_read;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_last;
  logic [NUM_EP-1:0] out_sel;
  logic         load;
  logic         drop;
  logic         flush;
  logic         emit_valid;

  // Token cycle looks at the live endpoint number, later cycles at the latched one.
  always_comb begin
    ep         = (state == ST_IDLE) ? bus.trn_endpoint : sel_ep;
    has_data   = 1'b0;
    ready_read = 1'b0;
    for (int i = 0; i < NUM_EP; i++) begin
      if (ep == 4'(i + 1)) begin
        has_data   = ep_in_has_data[i];
        ready_read = ep_out_ready[i];
      end
    end
  end

  assign bus.blk_xfer_in_has_data    = has_data;
  assign bus.blk_xfer_out_ready_read = ready_read;

  always_comb begin
    in_data      = '0;
    in_valid     = 1'b0;
    in_last      = 1'b0;
    ep_in_tready = '0;
    out_sel      = '0;
    for (int i = 0; i < NUM_EP; i++) begin
      out_sel[i] = (sel_ep == 4'(i + 1));
      if (state == ST_IN && sel_ep == 4'(i + 1)) begin
        in_data         = ep_in_tdata[8*i +: 8];
        in_valid        = ep_in_tvalid[i];
        in_last         = ep_in_tlast[i];
        ep_in_tready[i] = bus.blk_xfer_in_data_ready;
      end
    end
  end

  assign bus.blk_xfer_in_data       = in_data;
  assign bus.blk_xfer_in_data_valid = in_valid;
  assign bus.blk_xfer_in_data_last  = in_last;

  assign load  = (state == ST_OUT) && bus.blk_xfer_out_data_valid
               && acc && (count < MAX_C);
  assign drop  = (state == ST_OUT) && bus.blk_xfer_out_data_valid
               && acc && (count == MAX_C);
  assign flush = (state == ST_FLUSH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      sel_ep     <= '0;
      acc        <= 1'b0;
      count      <= '0;
      in_seen    <= 1'b0;
      nak_wait   <= 1'b0;
      out_xfer_q <= 1'b0;
      err_done   <= 1'b0;
      ep_out_err <= 1'b0;
    end else begin
      ep_out_err <= 1'b0;
      out_xfer_q <= bus.blk_out_xfer;
      unique case (state)
        ST_IDLE: begin
          if (bus.trn_start && bus.trn_type == TOK_IN) begin
            state    <= ST_IN;
            sel_ep   <= bus.trn_endpoint;
            in_seen  <= 1'b0;
            nak_wait <= 1'b0;
          end else if (bus.trn_start && bus.trn_type == TOK_OUT) begin
            state    <= ST_OUT;
            sel_ep   <= bus.trn_endpoint;
            acc      <= ready_read;
            count    <= '0;
            err_done <= 1'b0;
          end
        end
        ST_IN: begin
          // A NAKed IN never raises blk_in_xfer; give up after two idle cycles.
          if (bus.blk_in_xfer) in_seen <= 1'b1;
          else if (in_seen || nak_wait) state <= ST_IDLE;
          else nak_wait <= 1'b1;
        end
        ST_OUT: begin
          if (load) count <= count + 1'b1;
          if (drop && !err_done) begin
            ep_out_err <= 1'b1;
            err_done   <= 1'b1;
          end
          if (out_xfer_q && !bus.blk_out_xfer) state <= ST_FLUSH;
        end
        ST_FLUSH: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  usb_blk_ep_sched_out_hold u_hold (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .din        (bus.blk_xfer_out_data),
    .flush      (flush),
    .emit_valid (emit_valid),
    .emit_data  (ep_out_tdata),
    .emit_last  (ep_out_tlast)
  );

  assign ep_out_tvalid = emit_valid ? out_sel : '0;

endmodule

// File: tb/tb_usb_blk_ep_sched.sv
// Directed bench for usb_blk_ep_sched with IN/OUT scoreboards.
// Expected beats are queued at drive time and popped by monitors.
module tb_usb_blk_ep_sched;
  import usb_blk_ep_sched_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ep_in_has_data;
  logic [31:0] ep_in_tdata;
  logic [3:0] ep_in_tvalid;
  logic [3:0] ep_in_tlast;
  logic [3:0] ep_in_tready;
  logic [3:0] ep_out_ready;
  logic [7:0] ep_out_tdata;
  logic [3:0] ep_out_tvalid;
  logic       ep_out_tlast;
  logic       ep_out_err;

  usb_blk_ep_sched_if bus ();

  usb_blk_ep_sched #(.NUM_EP(4), .MAX_PKT(512)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .ep_in_has_data (ep_in_has_data),
    .ep_in_tdata    (ep_in_tdata),
    .ep_in_tvalid   (ep_in_tvalid),
    .ep_in_tlast    (ep_in_tlast),
    .ep_in_tready   (ep_in_tready),
    .ep_out_ready   (ep_out_ready),
    .ep_out_tdata   (ep_out_tdata),
    .ep_out_tvalid  (ep_out_tvalid),
    .ep_out_tlast   (ep_out_tlast),
    .ep_out_err     (ep_out_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int err_cnt = 0;
  logic bad_tready = 1'b0;
  logic [12:0] out_q[$];
  logic [8:0]  in_q[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // EP3 IN source: 8 bytes A0..A7; other EPs present junk that must stay unselected.
  logic in_run = 1'b0;
  int   ptr = 0;
  assign ep_in_tdata  = {8'hD4, 8'hA0 + 8'(ptr), 8'hD2, 8'hD1};
  assign ep_in_tvalid = in_run ? {1'b1, ptr < 8, 2'b11} : 4'b0;
  assign ep_in_tlast  = in_run ? {1'b1, ptr == 7, 2'b11} : 4'b0;

  always @(posedge clk) begin
    if (!in_run) ptr <= 0;
    else if (ep_in_tvalid[2] && ep_in_tready[2]) ptr <= ptr + 1;
  end

  always @(negedge clk) begin
    if ((ep_in_tready & 4'b1011) != 4'b0) bad_tready <= 1'b1;
    if (ep_out_err) err_cnt++;
    if (|ep_out_tvalid) begin
      if (out_q.size() == 0)
        chk("out_unexpected", {ep_out_tvalid, ep_out_tdata, ep_out_tlast}, 13'h0);
      else
        chk("out_beat", {ep_out_tvalid, ep_out_tdata, ep_out_tlast},
            out_q.pop_front());
    end
    if (bus.blk_xfer_in_data_valid && bus.blk_xfer_in_data_ready) begin
      if (in_q.size() == 0)
        chk("in_unexpected", {bus.blk_xfer_in_data, bus.blk_xfer_in_data_last}, 9'h0);
      else
        chk("in_beat", {bus.blk_xfer_in_data, bus.blk_xfer_in_data_last},
            in_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic token(input logic [1:0] t, input logic [3:0] e,
                       output logic hd, output logic rr);
    bus.trn_start    = 1'b1;
    bus.trn_type     = t;
    bus.trn_endpoint = e;
    @(negedge clk);
    hd = bus.blk_xfer_in_has_data;
    rr = bus.blk_xfer_out_ready_read;
    step();
    bus.trn_start    = 1'b0;
    bus.trn_endpoint = 4'd0;
  endtask

  task automatic out_pkt(input string tag, input logic [3:0] oh, input int n,
                         input logic [7:0] base, input logic exp);
    int lim;
    lim = (n < 512) ? n : 512;
    bus.blk_out_xfer = 1'b1;
    for (int k = 0; k < n; k++) begin
      bus.blk_xfer_out_data       = base + 8'(k);
      bus.blk_xfer_out_data_valid = 1'b1;
      if (exp && k < lim)
        out_q.push_back({oh, base + 8'(k), k == lim - 1});
      step();
    end
    bus.blk_xfer_out_data_valid = 1'b0;
    bus.blk_out_xfer = 1'b0;
    repeat (5) step();
    chk({tag, "_drain"}, out_q.size(), 0);
  endtask

  logic hd, rr;

  initial begin
    rst = 1'b1;
    bus.trn_start = 1'b0;
    bus.trn_type = TOK_OUT;
    bus.trn_endpoint = 4'd0;
    bus.blk_in_xfer = 1'b0;
    bus.blk_out_xfer = 1'b0;
    bus.blk_xfer_in_data_ready = 1'b0;
    bus.blk_xfer_out_data = 8'd0;
    bus.blk_xfer_out_data_valid = 1'b0;
    ep_in_has_data = 4'b0;
    ep_out_ready = 4'b0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_tvalid", ep_out_tvalid, 0);
    chk("rst_tlast", ep_out_tlast, 0);
    chk("rst_err", ep_out_err, 0);
    chk("rst_tdata", ep_out_tdata, 0);
    chk("rst_tready", ep_in_tready, 0);
    chk("rst_in_valid", bus.blk_xfer_in_data_valid, 0);
    step();
    rst = 1'b0;
    step();

    // OUT EP2, five bytes
    ep_out_ready = 4'b0010;
    token(TOK_OUT, 4'd2, hd, rr);
    chk("t1_ready_read", rr, 1);
    out_pkt("t1", 4'b0010, 5, 8'd11, 1'b1);
    chk("t1_err", err_cnt, 0);

    // OUT EP1 not ready: everything NAKed and discarded
    ep_out_ready = 4'b0000;
    token(TOK_OUT, 4'd1, hd, rr);
    chk("t2_ready_read", rr, 0);
    out_pkt("t2", 4'b0001, 64, 8'h40, 1'b0);

    // IN EP3, eight bytes with toggling ready
    ep_in_has_data = 4'b0100;
    in_run = 1'b1;
    token(TOK_IN, 4'd3, hd, rr);
    chk("t3_has_data", hd, 1);
    for (int i = 0; i < 8; i++) in_q.push_back({8'hA0 + 8'(i), i == 7});
    bus.blk_in_xfer = 1'b1;
    for (int c = 0; c < 40 && ptr < 8; c++) begin
      bus.blk_xfer_in_data_ready = c[0];
      step();
    end
    bus.blk_xfer_in_data_ready = 1'b0;
    bus.blk_in_xfer = 1'b0;
    repeat (2) step();
    chk("t3_in_drain", in_q.size(), 0);
    chk("t3_accepted", ptr, 8);
    chk("t3_tready_only_ep3", bad_tready, 0);
    in_run = 1'b0;
    step();

    // Invalid endpoints 0 and NUM_EP+1
    ep_in_has_data = 4'hF;
    ep_out_ready = 4'hF;
    in_run = 1'b1;
    bus.blk_xfer_in_data_ready = 1'b1;
    token(TOK_IN, 4'd0, hd, rr);
    chk("t4_in_ep0_has_data", hd, 0);
    repeat (4) step();
    token(TOK_IN, 4'd5, hd, rr);
    chk("t4_in_ep5_has_data", hd, 0);
    repeat (4) step();
    token(TOK_OUT, 4'd0, hd, rr);
    chk("t4_out_ep0_ready_read", rr, 0);
    out_pkt("t4a", 4'b0000, 4, 8'h70, 1'b0);
    token(TOK_OUT, 4'd5, hd, rr);
    chk("t4_out_ep5_ready_read", rr, 0);
    out_pkt("t4b", 4'b0000, 4, 8'h78, 1'b0);
    bus.blk_xfer_in_data_ready = 1'b0;
    in_run = 1'b0;
    ep_in_has_data = 4'b0;
    step();

    // Oversize OUT on EP4: 513 bytes, last one dropped
    ep_out_ready = 4'b1000;
    token(TOK_OUT, 4'd4, hd, rr);
    chk("t5_ready_read", rr, 1);
    out_pkt("t5", 4'b1000, 513, 8'd0, 1'b1);
    chk("t5_err_pulses", err_cnt, 1);

    // Reset after three OUT bytes on EP2
    ep_out_ready = 4'b0010;
    token(TOK_OUT, 4'd2, hd, rr);
    chk("t6_ready_read", rr, 1);
    bus.blk_out_xfer = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.blk_xfer_out_data = 8'h51 + 8'(k);
      bus.blk_xfer_out_data_valid = 1'b1;
      if (k < 2) out_q.push_back({4'b0010, 8'h51 + 8'(k), 1'b0});
      step();
    end
    bus.blk_xfer_out_data_valid = 1'b0;
    bus.blk_out_xfer = 1'b0;
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("t6_rst_tvalid", ep_out_tvalid, 0);
    chk("t6_rst_tlast", ep_out_tlast, 0);
    step();
    rst = 1'b0;
    repeat (3) step();
    chk("t6_partial_drain", out_q.size(), 0);
    token(TOK_OUT, 4'd2, hd, rr);
    chk("t6b_ready_read", rr, 1);
    out_pkt("t6b", 4'b0010, 4, 8'h61, 1'b1);

    chk("final_err_pulses", err_cnt, 1);
    chk("final_in_drain", in_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
